// File: rtl/fifo_rd_to_axis_pkg.sv
// fifo_axis_pkg: FIFO read-mode names and sizing helpers shared by the FIFO-to-AXIS reader
package fifo_axis_pkg;
  localparam string FWFT_TRUE = "true";
  localparam string FWFT_FALSE = "false";
  localparam int BUF_DEPTH = 2;
  function automatic int clogb2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin end
    return r;
  endfunction
  localparam int PTR_W = clogb2(BUF_DEPTH);
  localparam int OCC_W = clogb2(BUF_DEPTH + 1);
endpackage

// File: rtl/fifo_rd_to_axis_if.sv
// fifo_rd_to_axis_if: AXI-Stream data/valid/ready/last bundle
interface fifo_rd_to_axis_if #(parameter int data_width = 32);
  logic [data_width-1:0] data;
  logic valid;
  logic ready;
  logic last;
  modport master(output data, valid, last, input ready);
  modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/fifo_rd_to_axis_skid_buf2.sv
// axis_skid_buf2: two-entry circular output buffer with occupancy count
module axis_skid_buf2
  import fifo_axis_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [data_width-1:0] din,
  output logic [data_width-1:0] dout,
  output logic [OCC_W-1:0]      occ
);
  logic [data_width-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [OCC_W-1:0] occ_q;
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_q + PTR_W'(push);
      rd_q  <= rd_q + PTR_W'(pop);
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end
  assign dout = mem_q[rd_q];
  assign occ  = occ_q;
endmodule

// File: rtl/fifo_rd_to_axis.sv
// fifo_rd_to_axis: pops a sync FIFO (FWFT or latency-1) and streams words as AXIS with tlast framing
module fifo_rd_to_axis
  import fifo_axis_pkg::*;
#(
  parameter string fifo_fwft  = FWFT_TRUE,
  parameter int    data_width = 32,
  parameter int    len_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [len_width-1:0]  pkt_len,
  output logic                  fifo_ren,
  input  logic [data_width-1:0] fifo_dout,
  input  logic                  fifo_empty_n,
  fifo_rd_to_axis_if.master     m_axis,
  output logic                  pkt_done,
  output logic                  busy
);
  logic pop, push, inflight, done_q;
  logic [OCC_W-1:0] occ;
  logic [len_width-1:0] cnt_q, cnt_d, len_q, len_d;
  axis_skid_buf2 #(.data_width(data_width)) u_buf (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din(fifo_dout), .dout(m_axis.data), .occ(occ)
  );
  assign pop = m_axis.valid & m_axis.ready;
  assign m_axis.valid = occ != '0;
  // a read is issued only if its word is guaranteed a buffer slot when it lands
  assign fifo_ren = rst_n & en & fifo_empty_n &
                    ((3'(occ) + 3'(inflight) - 3'(pop)) < 3'(BUF_DEPTH));
  if (fifo_fwft == FWFT_FALSE) begin : g_std
    logic inflight_q;
    always_ff @(posedge clk) begin
      if (!rst_n) inflight_q <= 1'b0;
      else inflight_q <= fifo_ren;
    end
    assign inflight = inflight_q;
    assign push = inflight_q;
  end else begin : g_fwft
    assign inflight = 1'b0;
    assign push = fifo_ren;
  end
  assign m_axis.last = cnt_q == (cnt_q == '0 ? pkt_len : len_q);
  always_comb begin
    cnt_d = pop ? (m_axis.last ? '0 : cnt_q + 1'b1) : cnt_q;
    len_d = (pop && cnt_q == '0) ? pkt_len : len_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      done_q <= pop & m_axis.last;
    end
  end
  assign pkt_done = done_q;
  assign busy = m_axis.valid | inflight | (cnt_q != '0);
endmodule

// File: tb/tb_fifo_rd_to_axis.sv
// tb_fifo_rd_to_axis: runs an FWFT and a standard-mode reader side by side against queue-based FIFO and stream models
module tb_fifo_rd_to_axis;
  import fifo_axis_pkg::*;
  localparam int DW = 32;
  localparam int LW = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, en = 1'b0, ready = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic ren [2];
  logic empty_n [2];
  logic [DW-1:0] dout [2];
  logic done [2];
  logic busy [2];
  logic vld [2];
  logic lst [2];
  logic [DW-1:0] dat [2];
  logic [DW-1:0] fq [2][$];
  logic [DW-1:0] exp_q [2][$];
  int fill [2];
  int pos [2], cur_len [2], infl [2], cyc [2];
  int xfers [2], ndone [2];
  int first_ren [2], first_vld [2], first_x [2], last_x [2];
  bit done_exp [2], stall [2];
  logic [DW-1:0] s_dat [2];
  logic s_lst [2];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_m
    fifo_rd_to_axis_if #(.data_width(DW)) ax ();
    assign ax.ready = ready;
    assign vld[k] = ax.valid;
    assign lst[k] = ax.last;
    assign dat[k] = ax.data;
    if (k == 0) begin : g_dut
      fifo_rd_to_axis #(.fifo_fwft(FWFT_TRUE), .data_width(DW), .len_width(LW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pkt_len(pkt_len), .fifo_ren(ren[k]),
        .fifo_dout(dout[k]), .fifo_empty_n(empty_n[k]), .m_axis(ax),
        .pkt_done(done[k]), .busy(busy[k]));
    end else begin : g_dut
      fifo_rd_to_axis #(.fifo_fwft(FWFT_FALSE), .data_width(DW), .len_width(LW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pkt_len(pkt_len), .fifo_ren(ren[k]),
        .fifo_dout(dout[k]), .fifo_empty_n(empty_n[k]), .m_axis(ax),
        .pkt_done(done[k]), .busy(busy[k]));
    end

    initial begin
      empty_n[k] = 1'b0;
      dout[k] = '0;
    end

    // FIFO model: ren seen at the edge pops the head one step after the edge
    always @(posedge clk) begin : fifo_model
      bit r, rs;
      logic [DW-1:0] w;
      r = ren[k];
      rs = rst_n;
      #1;
      if (!rs) begin
        exp_q[k].delete();
        pos[k] = 0;
        done_exp[k] = 1'b0;
        stall[k] = 1'b0;
      end
      if (r && fq[k].size() != 0) begin
        w = fq[k].pop_front();
        exp_q[k].push_back(w);
        if (k == 1) dout[k] = w;
      end
      infl[k] = (k == 1 && r) ? 1 : 0;
      while (fill[k] > 0) begin
        fq[k].push_back($urandom);
        fill[k]--;
      end
      empty_n[k] = fq[k].size() != 0;
      if (k == 0) dout[k] = fq[k].size() != 0 ? fq[k][0] : '0;
      cyc[k]++;
    end

    // stream model: every handshake must deliver the oldest popped word with the framed tlast
    always @(negedge clk) begin : stream_model
      int l;
      bit el;
      logic [DW-1:0] e;
      if (rst_n) begin
        chk("ren_while_empty", ren[k] & ~empty_n[k], 0);
        chk("pkt_done", done[k], done_exp[k]);
        chk("valid", vld[k], exp_q[k].size() > infl[k]);
        chk("occupancy_le_2", (exp_q[k].size() - infl[k]) <= 2, 1);
        if (stall[k] && vld[k]) begin
          chk("data_stable", dat[k], s_dat[k]);
          chk("last_stable", lst[k], s_lst[k]);
        end
        if (done[k]) ndone[k]++;
        if (ren[k] && first_ren[k] < 0) first_ren[k] = cyc[k];
        if (vld[k] && first_vld[k] < 0) first_vld[k] = cyc[k];
        done_exp[k] = 1'b0;
        if (vld[k] && ready) begin
          if (exp_q[k].size() == 0) chk("spurious_beat", 1, 0);
          else begin
            e = exp_q[k].pop_front();
            l = (pos[k] == 0) ? int'(pkt_len) : cur_len[k];
            if (pos[k] == 0) cur_len[k] = int'(pkt_len);
            el = pos[k] == l;
            chk("data", dat[k], e);
            chk("last", lst[k], el);
            done_exp[k] = el;
            pos[k] = el ? 0 : pos[k] + 1;
          end
          xfers[k]++;
          if (first_x[k] < 0) first_x[k] = cyc[k];
          last_x[k] = cyc[k];
        end
        stall[k] = vld[k] & ~ready;
        s_dat[k] = dat[k];
        s_lst[k] = lst[k];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input int n);
    fill[0] = n;
    fill[1] = n;
  endtask

  task automatic mark();
    for (int k = 0; k < 2; k++) begin
      first_ren[k] = -1;
      first_vld[k] = -1;
      first_x[k] = -1;
      last_x[k] = -1;
    end
  endtask

  initial begin
    int x0 [2], d0 [2];
    for (int k = 0; k < 2; k++) begin
      fill[k] = 0; pos[k] = 0; cur_len[k] = 0; infl[k] = 0; cyc[k] = 0;
      xfers[k] = 0; ndone[k] = 0; done_exp[k] = 0; stall[k] = 0;
    end
    mark();
    rst_n = 1'b0; en = 1'b1; ready = 1'b0; pkt_len = 16'd3;
    load(8);
    step(3);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ren", ren[k], 0);
      chk("reset_valid", vld[k], 0);
      chk("reset_busy", busy[k], 0);
      chk("reset_done", done[k], 0);
    end
    // preloaded burst, ready high
    mark();
    for (int k = 0; k < 2; k++) begin x0[k] = xfers[k]; d0[k] = ndone[k]; end
    ready = 1'b1;
    rst_n = 1'b1;
    step(14);
    for (int k = 0; k < 2; k++) begin
      chk("first_valid_latency", first_vld[k] - first_ren[k], k == 0 ? 1 : 2);
      chk("no_bubbles", last_x[k] - first_x[k], 7);
      chk("burst_beats", xfers[k] - x0[k], 8);
      chk("burst_pkt_done", ndone[k] - d0[k], 2);
      chk("burst_idle", busy[k], 0);
    end
    // random backpressure over a 16-word stream
    for (int k = 0; k < 2; k++) x0[k] = xfers[k];
    load(16);
    for (int i = 0; i < 60; i++) begin
      ready = (i % 3 == 0) ? 1'b1 : 1'(($urandom % 4) == 0);
      step(1);
    end
    ready = 1'b1;
    step(10);
    for (int k = 0; k < 2; k++) begin
      chk("bp_beats", xfers[k] - x0[k], 16);
      chk("bp_drained", exp_q[k].size(), 0);
      chk("bp_idle", busy[k], 0);
    end
    // en low: buffered words drain, nothing new is read, packet position kept
    for (int k = 0; k < 2; k++) x0[k] = xfers[k];
    ready = 1'b0;
    load(8);
    step(5);
    en = 1'b0;
    ready = 1'b1;
    step(6);
    for (int k = 0; k < 2; k++) begin
      chk("en_low_drain", xfers[k] - x0[k], 2);
      chk("en_low_ren", ren[k], 0);
      chk("en_low_busy_midpkt", busy[k], 1);
    end
    en = 1'b1;
    step(12);
    for (int k = 0; k < 2; k++) chk("en_resume_beats", xfers[k] - x0[k], 8);
    // FIFO runs dry mid-packet
    for (int k = 0; k < 2; k++) begin x0[k] = xfers[k]; d0[k] = ndone[k]; end
    pkt_len = 16'd7;
    load(5);
    step(12);
    for (int k = 0; k < 2; k++) begin
      chk("dry_beats", xfers[k] - x0[k], 5);
      chk("dry_ren", ren[k], 0);
      chk("dry_busy", busy[k], 1);
      chk("dry_no_done", ndone[k] - d0[k], 0);
    end
    load(3);
    step(10);
    for (int k = 0; k < 2; k++) begin
      chk("refill_beats", xfers[k] - x0[k], 8);
      chk("refill_done", ndone[k] - d0[k], 1);
    end
    // single-beat packets, then a length change inside a packet
    for (int k = 0; k < 2; k++) d0[k] = ndone[k];
    pkt_len = 16'd0;
    load(4);
    step(10);
    for (int k = 0; k < 2; k++) chk("len0_done", ndone[k] - d0[k], 4);
    pkt_len = 16'd3;
    load(2);
    step(8);
    for (int k = 0; k < 2; k++) d0[k] = ndone[k];
    pkt_len = 16'd1;
    load(4);
    step(10);
    for (int k = 0; k < 2; k++) begin
      chk("len_change_done", ndone[k] - d0[k], 2);
      chk("len_change_idle", busy[k], 0);
    end
    // reset with full buffers mid-packet
    load(1);
    step(6);
    ready = 1'b0;
    load(4);
    step(6);
    for (int k = 0; k < 2; k++) chk("pre_reset_valid", vld[k], 1);
    rst_n = 1'b0;
    step(1);
    for (int k = 0; k < 2; k++) begin
      chk("mid_reset_valid", vld[k], 0);
      chk("mid_reset_busy", busy[k], 0);
      x0[k] = xfers[k];
      d0[k] = ndone[k];
    end
    rst_n = 1'b1;
    ready = 1'b1;
    step(12);
    for (int k = 0; k < 2; k++) begin
      chk("post_reset_beats", xfers[k] - x0[k], 2);
      chk("post_reset_done", ndone[k] - d0[k], 1);
    end
    // random traffic
    pkt_len = 16'd2;
    for (int i = 0; i < 300; i++) begin
      ready = 1'($urandom % 2);
      en = 1'(($urandom % 8) != 0);
      if (($urandom % 3) == 0) load(1);
      step(1);
    end
    en = 1'b1;
    ready = 1'b1;
    step(20);
    for (int k = 0; k < 2; k++) begin
      chk("rand_fifo_drained", fq[k].size(), 0);
      chk("rand_buf_drained", exp_q[k].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
